// File: rtl/scan_sequencer_138.sv
// -----------------------------------------------------------------------------
// scan_sequencer_138
//
// Drives a downstream 3-to-8 decoder through a masked channel scan. Each
// enabled channel is held for (dwell + 1) cycles. Every pointer position is
// preceded by a one-cycle blanking slot (SEEK), so two channels are never
// enabled back to back.
//
// Ports
//   clk        : single clock; all state changes on its rising edge
//   rst        : asynchronous active-high reset
//   start      : scan request, accepted only when idle and not busy
//   stop       : abort request; forces idle on the next edge (no done pulse)
//   continuous : 1 = wrap from channel 7 to 0 indefinitely (captured at start)
//   dwell      : active cycles per channel minus 1 (captured at start)
//   mask       : bit n enables channel n (captured at start)
//   I          : decoder enable code, 3'b100 = enabled, 3'b000 = disabled
//   S          : decoder channel select
//   busy       : high while a scan is in progress, including the done cycle
//   ch_valid   : high exactly when I == 3'b100
//   done       : one-cycle pulse on normal scan completion
//
// All outputs are registered. The state register (_p0) runs one cycle ahead
// of the output register: the outputs show, one edge later, what the state
// was doing. Abort and reset bypass that lag and clear the outputs directly.
// -----------------------------------------------------------------------------
module scan_sequencer_138 #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               continuous,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [7:0]         mask,
    output logic [2:0]         I,
    output logic [2:0]         S,
    output logic               busy,
    output logic               ch_valid,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEEK  = 2'd1,
        DWELL = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_p0;
    logic [2:0]         ptr_p0;
    logic [DWELL_W-1:0] cnt_p0;
    logic [7:0]         mask_r;
    logic [DWELL_W-1:0] dwell_r;
    logic               cont_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_p0 <= IDLE;
            ptr_p0   <= 3'd0;
            cnt_p0   <= '0;
            mask_r   <= 8'd0;
            dwell_r  <= '0;
            cont_r   <= 1'b0;
            I        <= 3'b000;
            S        <= 3'b000;
            busy     <= 1'b0;
            ch_valid <= 1'b0;
            done     <= 1'b0;
        end else if (state_p0 == IDLE) begin
            I        <= 3'b000;
            S        <= 3'b000;
            ch_valid <= 1'b0;
            done     <= 1'b0;
            // busy is still high during the done cycle, which keeps a start
            // held across the end of a scan from being taken on that edge.
            if (start && !stop && !busy) begin
                mask_r  <= mask;
                dwell_r <= dwell;
                cont_r  <= continuous;
                ptr_p0  <= 3'd0;
                busy    <= 1'b1;
                // An empty mask goes straight to DONE and never enables a channel.
                state_p0 <= (mask != 8'd0) ? SEEK : DONE;
            end else begin
                busy <= 1'b0;
            end
        end else if (stop) begin
            // Abort: outputs clear on this edge, so no done pulse and no
            // trailing enable.
            state_p0 <= IDLE;
            ptr_p0   <= 3'd0;
            cnt_p0   <= '0;
            I        <= 3'b000;
            S        <= 3'b000;
            busy     <= 1'b0;
            ch_valid <= 1'b0;
            done     <= 1'b0;
        end else begin
            // Output stage: present the phase the state register is in now.
            I        <= (state_p0 == DWELL) ? 3'b100 : 3'b000;
            S        <= (state_p0 == DONE) ? 3'b000 : ptr_p0;
            ch_valid <= (state_p0 == DWELL);
            done     <= (state_p0 == DONE);
            busy     <= 1'b1;

            case (state_p0)
                SEEK: begin
                    if (mask_r[ptr_p0]) begin
                        cnt_p0   <= dwell_r;
                        state_p0 <= DWELL;
                    end else if (ptr_p0 != 3'd7) begin
                        ptr_p0 <= ptr_p0 + 3'd1;
                    end else if (cont_r) begin
                        ptr_p0 <= 3'd0;
                    end else begin
                        state_p0 <= DONE;
                    end
                end
                DWELL: begin
                    if (cnt_p0 != '0) begin
                        cnt_p0 <= cnt_p0 - 1'b1;
                    end else if (ptr_p0 != 3'd7) begin
                        ptr_p0   <= ptr_p0 + 3'd1;
                        state_p0 <= SEEK;
                    end else if (cont_r) begin
                        ptr_p0   <= 3'd0;
                        state_p0 <= SEEK;
                    end else begin
                        state_p0 <= DONE;
                    end
                end
                DONE: begin
                    ptr_p0   <= 3'd0;
                    state_p0 <= IDLE;
                end
                default: state_p0 <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scan_sequencer_138.sv
// -----------------------------------------------------------------------------
// tb_scan_sequencer_138
//
// Randomized and directed bench for scan_sequencer_138. The expected output
// trace of a scan is built from the scan rules: a busy-only cycle after the
// start edge, then for each pointer a blanking slot followed, if enabled, by
// (dwell + 1) enabled cycles, then a done cycle. Outputs are packed as
// {I, S, busy, ch_valid, done}.
// -----------------------------------------------------------------------------
module tb_scan_sequencer_138;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          continuous = 1'b0;
    logic [DW-1:0] dwell = '0;
    logic [7:0]    mask = 8'd0;
    logic [2:0]    I;
    logic [2:0]    S;
    logic          busy;
    logic          ch_valid;
    logic          done;

    int         n_checks = 0;
    int         n_errors = 0;
    int         done_idx;
    logic [8:0] exp_q[$];

    always #5 clk = ~clk;

    scan_sequencer_138 #(.DWELL_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .continuous (continuous),
        .dwell      (dwell),
        .mask       (mask),
        .I          (I),
        .S          (S),
        .busy       (busy),
        .ch_valid   (ch_valid),
        .done       (done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, expv);
        end
    endtask

    function automatic logic [8:0] outs();
        return {I, S, busy, ch_valid, done};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected output trace, one entry per cycle starting after the start edge.
    task automatic build(input logic [7:0] m, input logic [DW-1:0] d, input bit c, input int limit);
        exp_q.delete();
        exp_q.push_back(9'b000_000_100);
        if (m == 8'd0) begin
            exp_q.push_back(9'b000_000_101);
            return;
        end
        for (int p = 0; exp_q.size() < limit; p = (p + 1) % 8) begin
            logic [2:0] ch;
            ch = p[2:0];
            exp_q.push_back({3'b000, ch, 3'b100});
            if (m[p])
                for (int k = 0; k <= int'(d); k++)
                    exp_q.push_back({3'b100, ch, 3'b110});
            if (p == 7 && !c)
                break;
        end
        if (!c)
            exp_q.push_back(9'b000_000_101);
    endtask

    // Runs one scan from idle and compares every cycle against the trace.
    // stop_at >= 0 raises stop for the edge following trace index stop_at.
    // junk drives random start/mask/dwell/continuous while the scan runs.
    task automatic run_scan(input logic [7:0] m, input logic [DW-1:0] d, input bit c,
                            input int stop_at, input bit junk, input string tag);
        bit         prev_en;
        logic [2:0] prev_s;
        build(m, d, c, c ? stop_at + 2 : 100000);
        start      = 1'b1;
        mask       = m;
        dwell      = d;
        continuous = c;
        stop       = 1'b0;
        step();
        done_idx = -1;
        prev_en  = 1'b0;
        prev_s   = 3'd0;
        for (int i = 0; i < exp_q.size(); i++) begin
            chk($sformatf("%s[%0d]", tag, i), outs(), exp_q[i]);
            chk($sformatf("%s_gap[%0d]", tag, i), (prev_en && I == 3'b100 && S != prev_s), 0);
            if (done && done_idx < 0)
                done_idx = i;
            prev_en = (I == 3'b100);
            prev_s  = S;
            stop = (i == stop_at);
            if (junk) begin
                start      = 1'($urandom);
                mask       = 8'($urandom);
                dwell      = DW'($urandom);
                continuous = 1'($urandom);
            end else begin
                start = 1'b0;
            end
            step();
            if (i == stop_at) begin
                chk($sformatf("%s_stop", tag), outs(), 0);
                stop  = 1'b0;
                start = 1'b0;
                step();
                chk($sformatf("%s_stop_idle", tag), outs(), 0);
                return;
            end
        end
        start = 1'b0;
        chk($sformatf("%s_idle", tag), outs(), 0);
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (2) step();
        chk("reset", outs(), 0);
        rst = 1'b0;
        step();
        chk("reset_idle", outs(), 0);

        // Two-channel scan with dwell 2: done lands on cycle 15
        run_scan(8'b0000_0101, 8'd2, 1'b0, -1, 1'b0, "r31");
        chk("r31_done_at", done_idx, 15);

        // Empty mask: done on the next cycle, never enabled
        run_scan(8'h00, 8'd0, 1'b0, -1, 1'b0, "r32");
        chk("r32_done_at", done_idx, 1);

        // Channel 7 only, continuous, then abort
        run_scan(8'h80, 8'd0, 1'b1, 40, 1'b0, "r33");

        // All channels, dwell 0: alternating blank/enable
        run_scan(8'hFF, 8'd0, 1'b0, -1, 1'b0, "r34");

        // Maximum dwell on one channel
        run_scan(8'h01, 8'hFF, 1'b0, -1, 1'b0, "dwmax");

        // Reset in the middle of a dwell on channel 3
        build(8'h08, 8'd5, 1'b0, 100000);
        start = 1'b1; mask = 8'h08; dwell = 8'd5; continuous = 1'b0;
        step();
        start = 1'b0;
        repeat (6) step();
        chk("r35_pre", outs(), exp_q[6]);
        #2 rst = 1'b1;
        #1 chk("r35_async", outs(), 0);
        step();
        chk("r35_held", outs(), 0);
        rst = 1'b0;
        step();
        chk("r35_release", outs(), 0);
        run_scan(8'h03, 8'd1, 1'b0, -1, 1'b0, "r35_next");

        // start together with stop in idle does nothing
        start = 1'b1; stop = 1'b1; mask = 8'hFF; dwell = 8'd0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("r36_ss[%0d]", k), outs(), 0);
        end
        start = 1'b0; stop = 1'b0;
        step();

        // Inputs toggling mid-scan have no effect on the captured scan
        run_scan(8'b0000_0101, 8'd2, 1'b0, -1, 1'b1, "r36_busy");
        chk("r36_done_at", done_idx, 15);

        // Randomized scans, some aborted
        for (int n = 0; n < 25; n++) begin
            logic [7:0]    m;
            logic [DW-1:0] d;
            bit            c;
            int            sa;
            m  = ($urandom % 6 == 0) ? 8'h00 : 8'($urandom);
            d  = DW'($urandom_range(0, 3));
            c  = ($urandom % 4 == 0);
            sa = c ? int'($urandom_range(3, 50))
                   : (($urandom % 3 == 0) ? int'($urandom_range(0, 30)) : -1);
            run_scan(m, d, c, sa, 1'b1, $sformatf("rnd%0d", n));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
